// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and default timing constants for the seven-segment display arbiter.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    localparam int DEF_HOLD_TICKS    = 32'sd4;
    localparam int DEF_TIMEOUT_TICKS = 32'sd16;

    // Four BCD-style nibbles, index k is digit k ({d3,d2,d1,d0}).
    typedef logic [3:0][3:0] digits_t;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting at a given
// index and returns the first hit as a one-hot vector and as an index.
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any_req
);

    logic [W-1:0] cand_s;
    logic         found_s;

    // Walk the requesters in priority order from start, keeping the first requester found.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found_s    = 1'b0;
        cand_s     = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = W'((int'(start) + i) % N);
            if (!found_s && req[cand_s]) begin
                found_s            = 1'b1;
                gnt_onehot[cand_s] = 1'b1;
                gnt_idx            = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        any_req = found_s;
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit display, with minimum hold,
// preemption timeout and a one-tick blank handoff. Optional blinking: SEG_ARB_BLINK_EN.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                       clk_4_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  digits_t [NUM_REQ-1:0]      data_i,
    input  logic [NUM_REQ-1:0][3:0]    en_i,
`ifdef SEG_ARB_BLINK_EN
    input  logic [NUM_REQ-1:0]         blink_i,
`endif
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic [3:0]                 digit0_o,
    output logic [3:0]                 digit1_o,
    output logic [3:0]                 digit2_o,
    output logic [3:0]                 digit3_o,
    output logic                       digit0_en_o,
    output logic                       digit1_en_o,
    output logic                       digit2_en_o,
    output logic                       digit3_en_o
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int HW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [OW-1:0]      LAST_IDX    = OW'(NUM_REQ - 1);
    localparam logic [HW-1:0]      HOLD_LIM    = HW'(HOLD_TICKS);
    localparam logic [HW-1:0]      TIMEOUT_LIM = HW'(TIMEOUT_TICKS);
    localparam logic [NUM_REQ-1:0] LSB_ONEHOT  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [OW-1:0]      owner_r;
    logic [OW-1:0]      last_owner_r;
    logic [HW-1:0]      hold_cnt_r;
    logic               busy_r;

    logic [OW-1:0]      start_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [OW-1:0]      pick_idx_s;
    logic               pick_any_s;
    logic               owner_req_s;
    logic               other_req_s;
    logic               timeout_s;
    logic               release_s;
    logic               grant_s;
    digits_t            digits_s;
    logic [3:0]         en_s;

    // Search starts one past the most recent owner so that owner ranks last.
    always_comb begin
        start_s = '0;
        if (last_owner_r >= LAST_IDX) begin
            start_s = '0;
        end else begin
            start_s = last_owner_r + OW'(1);
        end
    end

    rr_pick #(
        .N (NUM_REQ),
        .W (OW)
    ) u_rr_pick (
        .req        (req_i),
        .start      (start_s),
        .gnt_onehot (pick_onehot_s),
        .gnt_idx    (pick_idx_s),
        .any_req    (pick_any_s)
    );

    // Release decision for the current owner and new-grant qualifier.
    always_comb begin
        owner_req_s = req_i[owner_r];
        other_req_s = |(req_i & ~(LSB_ONEHOT << owner_r));
        timeout_s   = (hold_cnt_r >= TIMEOUT_LIM) && (hold_cnt_r >= HOLD_LIM);
        release_s   = !owner_req_s || (timeout_s && other_req_s);
        grant_s     = ((state_r == IDLE) || (state_r == HANDOFF)) && pick_any_s;
    end

    // Ownership state machine; HANDOFF arbitrates like IDLE so the next owner follows at once.
    always_ff @(posedge clk_4_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            gnt_r        <= '0;
            owner_r      <= '0;
            last_owner_r <= LAST_IDX;
            hold_cnt_r   <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, HANDOFF: begin
                    if (pick_any_s) begin
                        state_r    <= GRANTED;
                        gnt_r      <= pick_onehot_s;
                        owner_r    <= pick_idx_s;
                        hold_cnt_r <= '0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                GRANTED: begin
                    if (hold_cnt_r < TIMEOUT_LIM) begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                    if (release_s) begin
                        state_r      <= HANDOFF;
                        gnt_r        <= '0;
                        busy_r       <= 1'b0;
                        last_owner_r <= owner_r;
                    end else begin
                        state_r <= GRANTED;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG_ARB_BLINK_EN
    logic blink_tgl_r;

    // Blink phase: lit on every new grant, then flips each tick the display stays owned.
    always_ff @(posedge clk_4_i) begin
        if (rst_i) begin
            blink_tgl_r <= 1'b1;
        end else if (grant_s) begin
            blink_tgl_r <= 1'b1;
        end else if (state_r == GRANTED) begin
            blink_tgl_r <= ~blink_tgl_r;
        end else begin
            blink_tgl_r <= blink_tgl_r;
        end
    end
`endif

    // Owner's digits pass straight through while granted; blank otherwise.
    always_comb begin
        digits_s = '0;
        en_s     = 4'h0;
        if (state_r == GRANTED) begin
            digits_s = data_i[owner_r];
            en_s     = en_i[owner_r];
`ifdef SEG_ARB_BLINK_EN
            if (blink_i[owner_r]) begin
                en_s = en_s & {4{blink_tgl_r}};
            end else begin
                en_s = en_s;
            end
`endif
        end else begin
            digits_s = '0;
            en_s     = 4'h0;
        end
    end

    assign gnt_o       = gnt_r;
    assign owner_o     = owner_r;
    assign busy_o      = busy_r;
    assign digit0_o    = digits_s[0];
    assign digit1_o    = digits_s[1];
    assign digit2_o    = digits_s[2];
    assign digit3_o    = digits_s[3];
    assign digit0_en_o = en_s[0];
    assign digit1_en_o = en_s[1];
    assign digit2_en_o = en_s[2];
    assign digit3_en_o = en_s[3];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed self-checking bench for seg_display_arbiter (NUM_REQ=3, HOLD 4, TIMEOUT 16).
module tb_seg_display_arbiter;

    logic             clk;
    logic             rst;
    logic [2:0]       req;
    logic [2:0][15:0] data;
    logic [2:0][3:0]  en;
`ifdef SEG_ARB_BLINK_EN
    logic [2:0]       blink;
`endif
    logic [2:0]       gnt;
    logic [1:0]       owner;
    logic             busy;
    logic [3:0]       d0, d1, d2, d3;
    logic             e0, e1, e2, e3;

    int checks = 0;
    int errors = 0;

    seg_display_arbiter #(
        .NUM_REQ       (3),
        .HOLD_TICKS    (4),
        .TIMEOUT_TICKS (16)
    ) dut (
        .clk_4_i     (clk),
        .rst_i       (rst),
        .req_i       (req),
        .data_i      (data),
        .en_i        (en),
`ifdef SEG_ARB_BLINK_EN
        .blink_i     (blink),
`endif
        .gnt_o       (gnt),
        .owner_o     (owner),
        .busy_o      (busy),
        .digit0_o    (d0),
        .digit1_o    (d1),
        .digit2_o    (d2),
        .digit3_o    (d3),
        .digit0_en_o (e0),
        .digit1_en_o (e1),
        .digit2_en_o (e2),
        .digit3_en_o (e3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, owner, busy, d3, d2, d1, d0, e3, e2, e1, e0} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b owner=%0d busy=%b digits=%h%h%h%h en=%b%b%b%b, want all zero",
                     gnt, owner, busy, d3, d2, d1, d0, e3, e2, e1, e0);
        end
        step();
        checks++;
        if ({gnt, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_no_req: got gnt=%b busy=%b, want 000/0", gnt, busy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 3'b001;
        #1;
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL grant_latency: got gnt=%b before edge, want 000", gnt);
        end
        step();
        checks++;
        if (gnt !== 3'b001 || busy !== 1'b1 || owner !== 2'd0) begin
            errors++;
            $display("FAIL basic_grant: got gnt=%b busy=%b owner=%0d, want 001/1/0", gnt, busy, owner);
        end
        checks++;
        if ({d3, d2, d1, d0} !== 16'h1234 || {e3, e2, e1, e0} !== 4'hF) begin
            errors++;
            $display("FAIL basic_digits: got %h en=%b%b%b%b, want 1234 en=1111", {d3, d2, d1, d0}, e3, e2, e1, e0);
        end
        req = 3'b000;
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || {e3, e2, e1, e0} !== 4'h0) begin
            errors++;
            $display("FAIL basic_handoff: got gnt=%b busy=%b en=%b%b%b%b, want 000/0/0000", gnt, busy, e3, e2, e1, e0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 3'b011;
        step();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL simul_first: got gnt=%b, want 001", gnt);
        end
        req = 3'b010;
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || {e3, e2, e1, e0} !== 4'h0) begin
            errors++;
            $display("FAIL simul_blank: got gnt=%b busy=%b en=%b%b%b%b, want 000/0/0000", gnt, busy, e3, e2, e1, e0);
        end
        step();
        checks++;
        if (gnt !== 3'b010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL simul_second: got gnt=%b owner=%0d, want 010/1", gnt, owner);
        end
        checks++;
        if ({d3, d2, d1, d0} !== 16'hABCD || {e3, e2, e1, e0} !== 4'h5) begin
            errors++;
            $display("FAIL simul_digits: got %h en=%b%b%b%b, want abcd en=0101", {d3, d2, d1, d0}, e3, e2, e1, e0);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        req = 3'b001;
        step();
        step();
        step();
        req = 3'b101;
        for (int k = 3; k <= 16; k++) begin
            step();
            checks++;
            if (gnt !== 3'b001) begin
                errors++;
                $display("FAIL preempt_hold: cycle %0d got gnt=%b, want 001", k, gnt);
            end
        end
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL preempt_handoff: got gnt=%b busy=%b, want 000/0", gnt, busy);
        end
        step();
        checks++;
        if (gnt !== 3'b100 || owner !== 2'd2 || {d3, d2, d1, d0} !== 16'h5678) begin
            errors++;
            $display("FAIL preempt_new_owner: got gnt=%b owner=%0d digits=%h, want 100/2/5678",
                     gnt, owner, {d3, d2, d1, d0});
        end
        req = 3'b001;
        step();
        step();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL preempt_rotate: got gnt=%b, want 001", gnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 3'b010;
        step();
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++;
            if (gnt !== 3'b010) begin
                errors++;
                $display("FAIL hold_long: cycle %0d got gnt=%b, want 010", k, gnt);
            end
        end
        req = 3'b011;
        step();
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL sat_preempt: got gnt=%b, want 000", gnt);
        end
        step();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL sat_next: got gnt=%b, want 001", gnt);
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        req = 3'b011;
        step();
        for (int k = 1; k <= 16; k++) begin
            step();
        end
        step();
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL sole_handoff: got gnt=%b, want 000", gnt);
        end
        req = 3'b001;
        step();
        checks++;
        if (gnt !== 3'b001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL sole_regrant: got gnt=%b owner=%0d, want 001/0", gnt, owner);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 3'b111;
        step();
        req = 3'b110;
        step();
        req = 3'b111;
        step();
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL rerequest_waits: got gnt=%b, want 010", gnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b001;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (gnt !== 3'b000 || busy !== 1'b0 || {e3, e2, e1, e0} !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: got gnt=%b busy=%b en=%b%b%b%b, want 000/0/0000", gnt, busy, e3, e2, e1, e0);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL reset_regrant: got gnt=%b, want 001", gnt);
        end
    endtask

`ifdef SEG_ARB_BLINK_EN
    task automatic test_blink();
        logic [3:0] want;
        do_reset();
        blink = 3'b001;
        req   = 3'b001;
        want  = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({e3, e2, e1, e0} !== want) begin
                errors++;
                $display("FAIL blink: tick %0d got en=%b%b%b%b, want %b", k, e3, e2, e1, e0, want);
            end
            want = ~want;
        end
        blink = 3'b000;
    endtask
`endif

    initial begin
        rst  = 1'b1;
        req  = 3'b000;
        data[0] = 16'h1234;
        data[1] = 16'hABCD;
        data[2] = 16'h5678;
        en[0] = 4'hF;
        en[1] = 4'h5;
        en[2] = 4'hA;
`ifdef SEG_ARB_BLINK_EN
        blink = 3'b000;
`endif
        test_reset();
        test_basic();
        test_simultaneous();
        test_preempt();
        test_saturate();
        test_sole_requester();
        test_back_to_back();
        test_reset_mid();
`ifdef SEG_ARB_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
